morse_keyer: RTL

- Sits directly downstream of the unit-time clock divider; consumes its divided clock as the Morse time base.
- Accepts one character code per handshake and plays it as a timed key waveform (dot/dash/gaps in unit intervals) on key_out, which drives the buzzer/LED stage.
- Runs entirely on the 100 MHz system clock. The divided clock is sampled as data, never used as a clock.

---
 rtl/morse_pkg.sv | 27 ++
 rtl/morse_rom.sv | 54 +++++
 rtl/morse_keyer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer and its companion stages.
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitAlign,
    StMark,
    StSpace,
    StLgap,
    StWgap
  } state_e;

  localparam logic [5:0] CODE_A         = 6'd0;
  localparam logic [5:0] CODE_DIGIT0    = 6'd26;
  localparam logic [5:0] CODE_SPACE     = 6'd36;
  localparam logic [5:0] CODE_MAX_VALID = 6'd35;

  // Silent units added after a letter gap to form a 7-unit word gap.
  localparam int unsigned WORD_GAP_UNITS = 4;

  // len = element count (1-5); pat = elements MSB-first, 1 = dash.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } rom_entry_t;

endpackage

// File: rtl/morse_rom.sv
// Combinational character-code to Morse element lookup (A-Z, 0-9).
// Codes outside 0-35 return an all-zero entry (len = 0).
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0]  char_code_i,
  output rom_entry_t  entry_o
);

  // Pure lookup; patterns are left-aligned in pat.
  always_comb begin
    entry_o = '{len: 3'd0, pat: 5'b00000};
    unique case (char_code_i)
      6'd0:  entry_o = '{len: 3'd2, pat: 5'b01000}; // A .-
      6'd1:  entry_o = '{len: 3'd4, pat: 5'b10000}; // B -...
      6'd2:  entry_o = '{len: 3'd4, pat: 5'b10100}; // C -.-.
      6'd3:  entry_o = '{len: 3'd3, pat: 5'b10000}; // D -..
      6'd4:  entry_o = '{len: 3'd1, pat: 5'b00000}; // E .
      6'd5:  entry_o = '{len: 3'd4, pat: 5'b00100}; // F ..-.
      6'd6:  entry_o = '{len: 3'd3, pat: 5'b11000}; // G --.
      6'd7:  entry_o = '{len: 3'd4, pat: 5'b00000}; // H ....
      6'd8:  entry_o = '{len: 3'd2, pat: 5'b00000}; // I ..
      6'd9:  entry_o = '{len: 3'd4, pat: 5'b01110}; // J .---
      6'd10: entry_o = '{len: 3'd3, pat: 5'b10100}; // K -.-
      6'd11: entry_o = '{len: 3'd4, pat: 5'b01000}; // L .-..
      6'd12: entry_o = '{len: 3'd2, pat: 5'b11000}; // M --
      6'd13: entry_o = '{len: 3'd2, pat: 5'b10000}; // N -.
      6'd14: entry_o = '{len: 3'd3, pat: 5'b11100}; // O ---
      6'd15: entry_o = '{len: 3'd4, pat: 5'b01100}; // P .--.
      6'd16: entry_o = '{len: 3'd4, pat: 5'b11010}; // Q --.-
      6'd17: entry_o = '{len: 3'd3, pat: 5'b01000}; // R .-.
      6'd18: entry_o = '{len: 3'd3, pat: 5'b00000}; // S ...
      6'd19: entry_o = '{len: 3'd1, pat: 5'b10000}; // T -
      6'd20: entry_o = '{len: 3'd3, pat: 5'b00100}; // U ..-
      6'd21: entry_o = '{len: 3'd4, pat: 5'b00010}; // V ...-
      6'd22: entry_o = '{len: 3'd3, pat: 5'b01100}; // W .--
      6'd23: entry_o = '{len: 3'd4, pat: 5'b10010}; // X -..-
      6'd24: entry_o = '{len: 3'd4, pat: 5'b10110}; // Y -.--
      6'd25: entry_o = '{len: 3'd4, pat: 5'b11000}; // Z --..
      6'd26: entry_o = '{len: 3'd5, pat: 5'b11111}; // 0
      6'd27: entry_o = '{len: 3'd5, pat: 5'b01111}; // 1
      6'd28: entry_o = '{len: 3'd5, pat: 5'b00111}; // 2
      6'd29: entry_o = '{len: 3'd5, pat: 5'b00011}; // 3
      6'd30: entry_o = '{len: 3'd5, pat: 5'b00001}; // 4
      6'd31: entry_o = '{len: 3'd5, pat: 5'b00000}; // 5
      6'd32: entry_o = '{len: 3'd5, pat: 5'b10000}; // 6
      6'd33: entry_o = '{len: 3'd5, pat: 5'b11000}; // 7
      6'd34: entry_o = '{len: 3'd5, pat: 5'b11100}; // 8
      6'd35: entry_o = '{len: 3'd5, pat: 5'b11110}; // 9
      default: entry_o = '{len: 3'd0, pat: 5'b00000};
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: plays one character code per handshake as a timed key waveform.
// unit_clk is sampled as data through a synchronizer; its rising edges are the
// unit time base. Optional word-space support for code 36 is enabled by the
// macro MORSE_WORD_GAP_EN; without it code 36 reports as invalid.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned LETTER_GAP_UNITS = 3,
  parameter int unsigned DASH_UNITS       = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       unit_clk_i,
  input  logic       char_valid_i,
  input  logic [5:0] char_code_i,
  output logic       char_ready_o,
  output logic       key_out_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       bad_code_o
);

  localparam int unsigned CntW = 8;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      len_q, len_d;
  logic [4:0]      pat_q, pat_d;
  logic            key_q, key_d;
  logic            done_q, done_d;
  logic            bad_q, bad_d;
  logic            accept;
  rom_entry_t      rom_entry;

  morse_rom u_rom (
    .char_code_i (char_code_i),
    .entry_o     (rom_entry)
  );

  // Synchronize unit_clk and remember its last synchronized level for edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], unit_clk_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

  function automatic logic [CntW-1:0] elem_units(input logic is_dash);
    return is_dash ? CntW'(DASH_UNITS) : CntW'(1);
  endfunction

  assign char_ready_o = (state_q == StIdle) && !done_q;
  assign accept       = char_valid_i && char_ready_o;

  // Next-state and registered-output logic; every transition past accept waits on a tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pat_d   = pat_q;
    key_d   = key_q;
    done_d  = 1'b0;
    bad_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (char_code_i <= CODE_MAX_VALID) begin
            len_d   = rom_entry.len;
            pat_d   = rom_entry.pat;
            state_d = StWaitAlign;
          end
`ifdef MORSE_WORD_GAP_EN
          else if (char_code_i == CODE_SPACE) begin
            // len = 0 marks a word gap rather than a character.
            len_d   = 3'd0;
            pat_d   = 5'b00000;
            state_d = StWaitAlign;
          end
`endif
          else begin
            done_d = 1'b1;
            bad_d  = 1'b1;
          end
        end
      end
      StWaitAlign: begin
        if (tick) begin
          if (len_q == 3'd0) begin
            state_d = StWgap;
            cnt_d   = CntW'(WORD_GAP_UNITS);
          end else begin
            state_d = StMark;
            key_d   = 1'b1;
            cnt_d   = elem_units(pat_q[4]);
          end
        end
      end
      StMark: begin
        if (tick) begin
          if (cnt_q == CntW'(1)) begin
            key_d = 1'b0;
            if (len_q > 3'd1) begin
              state_d = StSpace;
            end else begin
              state_d = StLgap;
              cnt_d   = CntW'(LETTER_GAP_UNITS);
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StSpace: begin
        if (tick) begin
          state_d = StMark;
          key_d   = 1'b1;
          pat_d   = {pat_q[3:0], 1'b0};
          len_d   = len_q - 3'd1;
          cnt_d   = elem_units(pat_q[3]);
        end
      end
      StLgap, StWgap: begin
        if (tick) begin
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops the key immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= 3'd0;
      pat_q   <= 5'b00000;
      key_q   <= 1'b0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      key_q   <= key_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
    end
  end

  assign key_out_o  = key_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign bad_code_o = bad_q;

endmodule
